// File: rtl/skew_meter_pkg.sv
// Shared types for the skew measurement block.
package skew_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/skew_meter_sync2.sv
// Two-flop synchroniser bringing an asynchronous chain output into sys_clk.
module sync2 (
    input  logic sys_clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/skew_meter.sv
// Measures edge counts and disagreement between two synchronised chain outputs
// over a window of path-A periods; results leave through valid/ready.
module skew_meter
    import skew_meter_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             result_ready,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] edges_a,
    output logic [CNT_W-1:0] edges_b,
    output logic [CNT_W-1:0] xor_cycles,
    output logic [CNT_W-1:0] max_run,
    output logic             timeout
);

    localparam int unsigned        WIN_W     = WINDOW_LOG2 + 1;
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'((1 << WINDOW_LOG2) - 1);
    localparam int unsigned        IDLE_W    = $clog2(TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_t state, state_next;

    logic a_s, b_s;
    logic a_d, b_d;
    logic a_rise, b_rise, a_toggle, differ;

    logic [WIN_W-1:0]  win_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  run_inc;

    logic arm_clear;
    logic meas_en;
    logic idle_expired;
    logic timeout_hit;

    (* KEEP_HIERARCHY = "TRUE" *)
    sync2 u_sync_a (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (a_in),
        .q       (a_s)
    );

    (* KEEP_HIERARCHY = "TRUE" *)
    sync2 u_sync_b (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (b_in),
        .q       (b_s)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            a_d <= '0;
            b_d <= '0;
        end else begin
            a_d <= a_s;
            b_d <= b_s;
        end
    end

    assign a_rise   = a_s & ~a_d;
    assign b_rise   = b_s & ~b_d;
    assign a_toggle = a_s ^ a_d;
    assign differ   = a_s ^ b_s;
    assign run_inc  = sat_inc(run_cnt);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        arm_clear    = 1'b0;
        meas_en      = 1'b0;
        timeout_hit  = 1'b0;
        idle_expired = (idle_cnt == IDLE_LAST) && !a_toggle;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ARM;
                    arm_clear  = 1'b1;
                end
            end
            ST_ARM: begin
                if (a_rise) begin
                    state_next = ST_MEASURE;
                end else if (idle_expired) begin
                    state_next  = ST_DONE;
                    timeout_hit = 1'b1;
                end
            end
            ST_MEASURE: begin
                meas_en = 1'b1;
                if (a_rise && (win_cnt == WIN_LAST)) begin
                    state_next = ST_DONE;
                end else if (idle_expired) begin
                    state_next  = ST_DONE;
                    timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here, even alongside the handshake
                if (result_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Idle counter only advances while waiting on A; any A transition rearms it.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (arm_clear || a_toggle) begin
            idle_cnt <= '0;
        end else if ((state == ST_ARM) || (state == ST_MEASURE)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            edges_a    <= '0;
            edges_b    <= '0;
            xor_cycles <= '0;
            max_run    <= '0;
            run_cnt    <= '0;
            win_cnt    <= '0;
            timeout    <= '0;
        end else if (arm_clear) begin
            edges_a    <= '0;
            edges_b    <= '0;
            xor_cycles <= '0;
            max_run    <= '0;
            run_cnt    <= '0;
            win_cnt    <= '0;
            timeout    <= '0;
        end else begin
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
            if (meas_en) begin
                if (a_rise) begin
                    edges_a <= sat_inc(edges_a);
                    win_cnt <= win_cnt + WIN_W'(1);
                end
                if (b_rise) begin
                    edges_b <= sat_inc(edges_b);
                end
                if (differ) begin
                    xor_cycles <= sat_inc(xor_cycles);
                    run_cnt    <= run_inc;
                    if (run_inc > max_run) begin
                        max_run <= run_inc;
                    end
                end else begin
                    run_cnt <= '0;
                end
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_skew_meter.sv
// Directed and randomized bench for skew_meter with an array-based reference of
// the windowed edge/disagreement measurement.
module tb_skew_meter;

    localparam int unsigned W_LOG2 = 3;
    localparam int unsigned CW     = 6;
    localparam int unsigned TO     = 1024;
    localparam int          CMAX   = (1 << CW) - 1;
    localparam int          NWIN   = 1 << W_LOG2;
    localparam int          HMAX   = 32768;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          start;
    logic          a_in;
    logic          b_in;
    logic          result_ready;
    logic          busy;
    logic          result_valid;
    logic [CW-1:0] edges_a;
    logic [CW-1:0] edges_b;
    logic [CW-1:0] xor_cycles;
    logic [CW-1:0] max_run;
    logic          timeout;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Waveform configuration; B shares A's period unless b_rand is set.
    int a_per   = 8;
    int a_hi    = 4;
    int b_hi    = 4;
    int b_lag   = 0;
    bit a_stuck = 1'b0;
    bit b_rand  = 1'b0;

    // Input value driven just after each sys_clk edge, indexed by edge number.
    bit ha [HMAX];
    bit hb [HMAX];

    always #5 sys_clk = ~sys_clk;

    skew_meter #(
        .WINDOW_LOG2 (W_LOG2),
        .CNT_W       (CW),
        .TIMEOUT     (TO)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .start        (start),
        .a_in         (a_in),
        .b_in         (b_in),
        .result_ready (result_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .edges_a      (edges_a),
        .edges_b      (edges_b),
        .xor_cycles   (xor_cycles),
        .max_run      (max_run),
        .timeout      (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit wave(input int t, input int per, input int hi, input int lag);
        return ((t + 1000 * per - lag) % per) < hi;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL history_overflow: observed %0d expected <%0d", cyc, HMAX);
            $fatal(1, "history overflow");
        end
        a_in = a_stuck ? 1'b0 : wave(cyc, a_per, a_hi, 0);
        b_in = b_rand ? 1'($urandom % 2) : wave(cyc, a_per, b_hi, b_lag);
        ha[cyc] = a_in;
        hb[cyc] = b_in;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Synced values reach the FSM 3 edges after being driven, so the first
    // rise that can arm after a start driven at edge s is the one driven at s-1.
    function automatic void model(input int s, output int idone, output int ea,
                                  output int eb, output int xr, output int mr);
        int i0;
        int n;
        int run;
        i0 = -1; n = 0; run = 0;
        idone = -1; ea = 0; eb = 0; xr = 0; mr = 0;
        for (int i = s - 1; i <= cyc && idone < 0; i++) begin
            bit ra;
            bit rb;
            ra = ha[i] && !ha[i-1];
            rb = hb[i] && !hb[i-1];
            if (i0 < 0) begin
                if (ra) i0 = i;
            end else begin
                if (ra) begin ea++; n++; end
                if (rb) eb++;
                if (ha[i] != hb[i]) begin
                    xr++;
                    run++;
                    if (run > mr) mr = run;
                end else begin
                    run = 0;
                end
                if (n == NWIN) idone = i;
            end
        end
        if (ea > CMAX) ea = CMAX;
        if (eb > CMAX) eb = CMAX;
        if (xr > CMAX) xr = CMAX;
        if (mr > CMAX) mr = CMAX;
    endfunction

    task automatic measure(input string tag, output int s, output int e_done);
        step();
        start = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
        check({tag, "_busy_on_arm"}, 32'(busy), 32'd1);
        e_done = -1;
        for (int k = 0; k < 2000 && e_done < 0; k++) begin
            step();
            if (result_valid === 1'b1) e_done = cyc;
        end
        check({tag, "_done_seen"}, 32'(e_done >= 0), 32'd1);
    endtask

    task automatic check_model(input string tag, input int s, input int e_done);
        int idone, ea, eb, xr, mr;
        model(s, idone, ea, eb, xr, mr);
        check({tag, "_latency"}, e_done, idone + 3);
        check({tag, "_edges_a"}, 32'(edges_a), ea);
        check({tag, "_edges_b"}, 32'(edges_b), eb);
        check({tag, "_xor"}, 32'(xor_cycles), xr);
        check({tag, "_max_run"}, 32'(max_run), mr);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic release_result(input string tag);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, "_idle_after_xfer"}, {30'd0, result_valid, busy}, 32'd0);
    endtask

    task automatic directed(input string tag, input int per, input int hi, input int lag,
                            input int x_exp, input int r_exp);
        int s, e;
        a_stuck = 1'b0; b_rand = 1'b0;
        a_per = per; a_hi = hi; b_hi = hi; b_lag = lag;
        steps(2 * per + 4);
        measure(tag, s, e);
        check_model(tag, s, e);
        check({tag, "_ea_const"}, 32'(edges_a), 32'd8);
        check({tag, "_eb_const"}, 32'(edges_b), 32'd8);
        check({tag, "_xor_const"}, 32'(xor_cycles), x_exp);
        check({tag, "_run_const"}, 32'(max_run), r_exp);
        release_result(tag);
    endtask

    initial begin
        int s, e;
        logic [31:0] held;
        rst = 1'b1; start = 1'b0; result_ready = 1'b0; a_in = 1'b0; b_in = 1'b0;
        steps(3);
        check("reset_state", {busy, result_valid, edges_a, edges_b, xor_cycles, max_run, timeout}, 32'd0);
        rst = 1'b0;
        steps(4);

        directed("same_p8", 8, 4, 0, 0, 0);
        directed("lag1_p8", 8, 4, 1, 16, 1);
        directed("lag3_p16", 16, 8, 3, 48, 3);

        // A stuck low: timeout after exactly TO cycles in ARM, nothing counted.
        a_stuck = 1'b1; b_rand = 1'b1;
        steps(10);
        measure("stuck", s, e);
        check("stuck_latency", e, s + 1 + TO);
        check("stuck_timeout", 32'(timeout), 32'd1);
        check("stuck_counts", {edges_a, edges_b, xor_cycles, max_run}, 32'd0);
        release_result("stuck");

        // Back-pressure: fields held for 50 cycles, start during DONE ignored.
        a_stuck = 1'b0; b_rand = 1'b0;
        a_per = 8; a_hi = 4; b_hi = 4; b_lag = 1;
        steps(20);
        measure("bp", s, e);
        held = {5'd0, 1'b1, 1'b1, 6'd8, 6'd8, 6'd16, 6'd1, 1'b0};
        for (int k = 0; k < 50; k++) begin
            start = (k == 20);
            step();
            check("bp_hold", {5'd0, result_valid, busy, edges_a, edges_b, xor_cycles, max_run, timeout}, held);
        end
        start = 1'b1;
        result_ready = 1'b1;
        step();
        start = 1'b0;
        result_ready = 1'b0;
        check("bp_xfer", {30'd0, result_valid, busy}, 32'd0);
        steps(3);
        check("bp_start_ignored", 32'(busy), 32'd0);
        check("bp_fields_kept", {edges_a, edges_b, xor_cycles, max_run, timeout}, {6'd8, 6'd8, 6'd16, 6'd1, 1'b0});

        // Asynchronous reset in the middle of MEASURE.
        steps(12);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        e = -1;
        for (int k = 0; k < 200 && e < 0; k++) begin
            step();
            if (edges_a == CW'(4)) e = cyc;
        end
        check("rst_reached_4_edges", 32'(e >= 0), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_immediate", {busy, result_valid, edges_a, edges_b, xor_cycles, max_run, timeout}, 32'd0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            check("rst_stays_idle", {30'd0, result_valid, busy}, 32'd0);
        end
        measure("rst_fresh", s, e);
        check_model("rst_fresh", s, e);
        release_result("rst_fresh");

        // Randomized waveforms: short and long periods, random B, random ready.
        for (int it = 0; it < 8; it++) begin
            a_stuck = 1'b0;
            a_per   = (it % 2 == 0) ? int'($urandom_range(3, 40)) : int'($urandom_range(70, 150));
            a_hi    = int'($urandom_range(1, a_per - 1));
            b_hi    = int'($urandom_range(1, a_per - 1));
            b_lag   = int'($urandom_range(0, a_per - 1));
            b_rand  = ($urandom % 3) == 0;
            result_ready = 1'($urandom % 2);
            steps(2 * a_per + 4);
            measure("rand", s, e);
            check_model("rand", s, e);
            release_result("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
